// File: rtl/gs_div_pkg.sv
`default_nettype none
// ============================================================================
// gs_div_pkg : shared FSM encoding and fixed-point helpers for gs_divider
// Revision   : 1.0
// ============================================================================
package gs_div_pkg;

    localparam int ITER_MIN    = 1;
    localparam int ITER_MAX    = 15;
    // Integer bits of the 2*WIDTH fixed-point datapath; values stay below 4.0
    localparam int FP_INT_BITS = 2;

    function automatic int frac_bits(input int width);
        return 2 * width - FP_INT_BITS;
    endfunction

    typedef logic [2:0] gs_state_t;

    localparam gs_state_t S_IDLE = 3'd0;
    localparam gs_state_t S_NORM = 3'd1;
    localparam gs_state_t S_ITER = 3'd2;
    localparam gs_state_t S_QUOT = 3'd3;
    localparam gs_state_t S_CORR = 3'd4;

endpackage
`default_nettype wire

// File: rtl/gs_clz.sv
`default_nettype none
// ============================================================================
// gs_clz   : leading-zero counter, returns WIDTH for an all-zero input
// Revision : 1.0
// ============================================================================
module gs_clz #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [CW-1:0]    count_o
);

    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value_i[i]) begin
                count_o = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gs_divider.sv
`default_nettype none
// ============================================================================
// gs_divider : multi-cycle Goldschmidt divider, signed/unsigned, with abort.
//              Optional ovf output enabled by macro GS_DIVIDER_OVF_FLAG_EN.
// Revision   : 1.0
// ============================================================================
module gs_divider
    import gs_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
`ifdef GS_DIVIDER_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int FW   = 2 * WIDTH;
    localparam int FRAC = frac_bits(WIDTH);
    localparam int CW   = $clog2(WIDTH) + 1;
    localparam int SW   = $clog2(4 * WIDTH) + 1;
    localparam int PW   = 2 * WIDTH + 2;
    localparam logic [FW-1:0] C_TWO = {2'b10, {(FW-2){1'b0}}};

    if (ITER < ITER_MIN || ITER > ITER_MAX) begin : g_iter_range
        $error("gs_divider: ITER out of range");
    end

    gs_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [FW-1:0]    n_q, n_d, d_q, d_d;
    logic [CW-1:0]    la_q, la_d, lb_q, lb_d;
    logic [3:0]       iter_q, iter_d;
    logic [WIDTH:0]   qe_q, qe_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic             ph_q, ph_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dz_q, dz_d;
`ifdef GS_DIVIDER_OVF_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic             w_a_neg, w_b_neg, w_qneg;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_an, w_bn, w_qmag, w_rmag;
    logic [CW-1:0]    w_la, w_lb;
    logic [FW-1:0]    w_f;
    logic [SW-1:0]    w_sh;
    logic [PW-1:0]    w_r;

    assign w_a_neg = sgn_q & a_q[WIDTH-1];
    assign w_b_neg = sgn_q & b_q[WIDTH-1];
    assign w_qneg  = w_a_neg ^ w_b_neg;
    assign w_mag_a = w_a_neg ? -a_q : a_q;
    assign w_mag_b = w_b_neg ? -b_q : b_q;

    gs_clz #(.WIDTH(WIDTH), .CW(CW)) u_clz_a (.value_i(w_mag_a), .count_o(w_la));
    gs_clz #(.WIDTH(WIDTH), .CW(CW)) u_clz_b (.value_i(w_mag_b), .count_o(w_lb));

    assign w_an = w_mag_a << w_la;
    assign w_bn = w_mag_b << w_lb;
    assign w_f  = C_TWO - d_q;
    // N holds an/bn; the true quotient is N scaled by 2^(lb-la)
    assign w_sh = SW'(FRAC) + SW'(la_q) - SW'(lb_q);
    assign w_r  = PW'(w_mag_a) - prod_q;

    // The Goldschmidt estimate is within one of the exact quotient
    always_comb begin
        w_qmag = WIDTH'(qe_q);
        w_rmag = WIDTH'(w_r);
        if (w_r[PW-1]) begin
            w_qmag = WIDTH'(qe_q - (WIDTH+1)'(1));
            w_rmag = WIDTH'(w_r + PW'(w_mag_b));
        end else if (w_r >= PW'(w_mag_b)) begin
            w_qmag = WIDTH'(qe_q + (WIDTH+1)'(1));
            w_rmag = WIDTH'(w_r - PW'(w_mag_b));
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        n_d     = n_q;
        d_d     = d_q;
        la_d    = la_q;
        lb_d    = lb_q;
        iter_d  = iter_q;
        qe_d    = qe_q;
        prod_d  = prod_q;
        ph_d    = ph_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef GS_DIVIDER_OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = signed_op;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                n_d     = {2'b00, w_an, {(WIDTH-2){1'b0}}};
                d_d     = {2'b00, w_bn, {(WIDTH-2){1'b0}}};
                la_d    = w_la;
                lb_d    = w_lb;
                iter_d  = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                n_d    = FW'(({{FW{1'b0}}, n_q} * {{FW{1'b0}}, w_f}) >> FRAC);
                d_d    = FW'(({{FW{1'b0}}, d_q} * {{FW{1'b0}}, w_f}) >> FRAC);
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(ITER - 1)) begin
                    state_d = S_QUOT;
                end
            end
            S_QUOT: begin
                qe_d    = (WIDTH+1)'(({1'b0, n_q} + ((FW+1)'(1) << (w_sh - SW'(1)))) >> w_sh);
                ph_d    = 1'b0;
                state_d = S_CORR;
            end
            S_CORR: begin
                // First CORR cycle registers q*|b| so the multiplier sits alone
                if (!ph_q) begin
                    prod_d = PW'(qe_q) * PW'(w_mag_b);
                    ph_d   = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    dz_d    = (b_q == '0);
                    if (b_q == '0) begin
                        quot_d = '1;
                        rem_d  = a_q;
                    end else begin
                        quot_d = w_qneg  ? -w_qmag : w_qmag;
                        rem_d  = w_a_neg ? -w_rmag : w_rmag;
                    end
`ifdef GS_DIVIDER_OVF_FLAG_EN
                    ovf_d = sgn_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            quot_d  = quot_q;
            rem_d   = rem_q;
            dz_d    = dz_q;
`ifdef GS_DIVIDER_OVF_FLAG_EN
            ovf_d   = ovf_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            n_q     <= '0;
            d_q     <= '0;
            la_q    <= '0;
            lb_q    <= '0;
            iter_q  <= '0;
            qe_q    <= '0;
            prod_q  <= '0;
            ph_q    <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
`ifdef GS_DIVIDER_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            n_q     <= n_d;
            d_q     <= d_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            iter_q  <= iter_d;
            qe_q    <= qe_d;
            prod_q  <= prod_d;
            ph_q    <= ph_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef GS_DIVIDER_OVF_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
`ifdef GS_DIVIDER_OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire
